sdram_arbiter: RTL and testbench
================================

# sdram_arbiter

Round-robin arbiter that shares the single internal access port of the SDRAM controller between `NUM_PORTS` requesters, such as a CPU instruction fetch, a CPU data port and a video/DMA reader. It sits between the requesters and the controller's `adr/dat/sel/acc/we/ack` interface. It grants one owner at a time and routes that owner's request to the controller. The controller's `ack` is returned only to the owner; read data and address are broadcast to all ports.

## Interface
- `NUM_PORTS`, 3: number of requesters; 2..8.
- `MAX_HOLD`, 8: number of acks an owner may collect before it is preempted while others wait (fairness build only); 1..255.
- `sdram_clk` in 1: clock; all logic on the rising edge.
- `sdram_rst_n` in 1: reset, asynchronous, active-low.
- `p_adr_i` in `NUM_PORTS*32`: per-port address; port k at `[32k+31:32k]`.
- `p_dat_i` in `NUM_PORTS*16`: per-port write data.
- `p_sel_i` in `NUM_PORTS*2`: per-port byte selects.
- `p_we_i` in `NUM_PORTS`: per-port write enable.
- `p_acc_i` in `NUM_PORTS`: per-port access request; held high until ack.
- `p_ack_o` out `NUM_PORTS`: per-port ack; only the owner's bit can be high.
- `p_dat_o` out 16: read data, broadcast; equals `dat_i`.
- `p_adr_o` out 32: beat address, broadcast; equals `adr_i`.
- `grant_o` out `NUM_PORTS`: one-hot current owner; 0 when there is no owner.
- `adr_o` out 32, `dat_o` out 16, `sel_o` out 2, `we_o` out 1, `acc_o` out 1: request to the controller.
- `ack_i` in 1, `dat_i` in 16, `adr_i` in 32: response from the controller.

## Operation
- State machine with two states.
  - **ARB** (no owner): `grant_o`=0, `acc_o`=0.
  - **OWN**: owner index `own` is registered.
- ARB -> OWN when any `p_acc_i` bit is high.
  - `own` is the first requesting port at or after `(last+1) mod NUM_PORTS`.
  - `last` is updated to `own` on the same edge.
- In OWN:
  - `adr_o/dat_o/sel_o/we_o` combinationally select port `own`.
  - `acc_o = p_acc_i[own] & ~mask`.
  - `p_ack_o[own] = ack_i`; all other ack bits are 0.
- OWN -> ARB when `p_acc_i[own]` is low, sampled on a cycle with no `ack_i`.
  - If `ack_i` and acc-drop coincide, the ack is still delivered, and the transition happens on that edge.
- `hold_cnt` (8-bit):
  - Cleared on entry to OWN.
  - Incremented on each `ack_i` while in OWN.
  - Saturates at 255.
- Read bursts: the controller gives one ack with the first beat, then streams the remaining beats on `dat_i/adr_i`. Because these are broadcast, a grant change during a burst cannot misroute data. The owner qualifies beats by its own address.
- If `ack_i` arrives in ARB (it must not), it is dropped and no port is acked.
- `NUM_PORTS`=1 is not supported.

## Timing
- Reset values:
  - State ARB, `last`=`NUM_PORTS-1` (so port 0 wins first), `hold_cnt`=0.
  - `grant_o`=0, `acc_o`=0, `p_ack_o`=0.
  - `adr_o/dat_o/sel_o/we_o` are 0 because no port is selected.
  - `p_dat_o/p_adr_o` follow the inputs.
- Arbitration latency: 1 cycle from `p_acc_i` rising to `acc_o` rising.
- Back-to-back accesses by the same owner add no extra latency.
- Owner change costs 1 idle cycle, which is spent in ARB.
- `ack` path is combinational: zero-cycle latency from `ack_i` to `p_ack_o`.
- Simultaneous requests from all ports are served strictly in rotation 0, 1, 2, 0, …
- Reset asserted mid-transaction:
  - All outputs go to reset values immediately.
  - The controller is expected to be reset by the same source.

## Configuration
- `SDRAM_ARB_FAIRNESS_EN` defined: preemption is enabled.
  - When `ack_i` arrives with `hold_cnt == MAX_HOLD-1` and another port has `p_acc_i` high, `mask` is set for the rest of that cycle.
  - `acc_o` is then 0, the ack is delivered, and the state goes to ARB on that edge.
  - The preempted port keeps requesting and is rotated back in later.
- Not defined: `mask`=0 always. The owner keeps the grant until it drops `p_acc_i`. `hold_cnt` may be removed by synthesis.

## Test plan
- **Reset:** hold `sdram_rst_n`=0 with all `p_acc_i`=1, then release.
  - During reset: `grant_o`=0, `acc_o`=0.
  - One cycle after release: `grant_o`=3'b001 and `acc_o`=1.
- **Single write:** port 1 drives `adr`=0x0000_1234, `dat`=0xBEEF, `sel`=2'b11, `we`=1.
  - `adr_o/dat_o/we_o` match the port-1 values.
  - `ack_i` pulse gives `p_ack_o`=3'b010.
  - Port 1 drops `acc`; `grant_o`=0 on the next cycle.
- **Round robin:** all three ports each request a single access.
  - Grants occur in order 001, 010, 100, 001, with one ARB cycle between grants.
- **Read burst broadcast:** port 2 reads 0x100 and receives one ack.
  - Port 0 is granted during the streamed beats.
  - `p_dat_o/p_adr_o` carry 0x102..0x10E unchanged.
  - No ack goes to port 0 until the controller acks it.
- **Fairness on** (`SDRAM_ARB_FAIRNESS_EN`, `MAX_HOLD`=4): port 0 requests continuously while port 1 waits.
  - On port 0's 4th ack, `acc_o`=0 in that cycle.
  - Next cycle is ARB; port 1 is granted the cycle after.
- **Fairness off:** same stimulus as the previous scenario.
  - Port 0 keeps the grant through 20 acks.
  - Port 1 is granted only after port 0 drops `acc`.

Source files
------------

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin arbiter sharing the SDRAM controller access port between NUM_PORTS requesters.
// Define SDRAM_ARB_FAIRNESS_EN to preempt an owner after MAX_HOLD acks while another port waits.
module sdram_arbiter #(
  parameter int NUM_PORTS = 3,
  parameter int MAX_HOLD  = 8
) (
  input  logic                    sdram_clk,
  input  logic                    sdram_rst_n,
  input  logic [NUM_PORTS*32-1:0] p_adr_i,
  input  logic [NUM_PORTS*16-1:0] p_dat_i,
  input  logic [NUM_PORTS*2-1:0]  p_sel_i,
  input  logic [NUM_PORTS-1:0]    p_we_i,
  input  logic [NUM_PORTS-1:0]    p_acc_i,
  output logic [NUM_PORTS-1:0]    p_ack_o,
  output logic [15:0]             p_dat_o,
  output logic [31:0]             p_adr_o,
  output logic [NUM_PORTS-1:0]    grant_o,
  output logic [31:0]             adr_o,
  output logic [15:0]             dat_o,
  output logic [1:0]              sel_o,
  output logic                    we_o,
  output logic                    acc_o,
  input  logic                    ack_i,
  input  logic [15:0]             dat_i,
  input  logic [31:0]             adr_i
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [0:0] {
    ST_ARB = 1'b0,
    ST_OWN = 1'b1
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [IDX_W-1:0]     own_r;
  logic [IDX_W-1:0]     own_nxt_s;
  logic [IDX_W-1:0]     last_r;
  logic [IDX_W-1:0]     last_nxt_s;
  logic [IDX_W-1:0]     pick_s;
  logic [NUM_PORTS-1:0] own_oh_s;
  logic                 mask_s;

  if (NUM_PORTS < 2 || NUM_PORTS > 8 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_param_check
    $error("sdram_arbiter: NUM_PORTS must be 2..8 and MAX_HOLD 1..255");
  end

  // Port index 'offset' positions after the one just after base, wrapped into 0..NUM_PORTS-1.
  function automatic logic [IDX_W-1:0] rr_slot(input logic [IDX_W-1:0] base, input int offset);
    int idx;
    idx = int'(base) + 1 + offset;
    if (idx >= NUM_PORTS) begin
      idx = idx - NUM_PORTS;
    end else begin
      idx = idx;
    end
    return IDX_W'(idx);
  endfunction

  // Round-robin pick: scanning from the far end lets the nearest requester overwrite the rest.
  always_comb begin
    pick_s = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (p_acc_i[rr_slot(last_r, i)]) begin
        pick_s = rr_slot(last_r, i);
      end else begin
        pick_s = pick_s;
      end
    end
  end

  // One-hot view of the current owner index.
  always_comb begin
    own_oh_s        = '0;
    own_oh_s[own_r] = 1'b1;
  end

`ifdef SDRAM_ARB_FAIRNESS_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] hold_cnt_r;
  logic [7:0] hold_cnt_nxt_s;

  // Preempt on the ack that completes the owner's quota when someone else is waiting.
  always_comb begin
    if ((state_r == ST_OWN) && ack_i && (hold_cnt_r == HOLD_LAST) && (|(p_acc_i & ~own_oh_s))) begin
      mask_s = 1'b1;
    end else begin
      mask_s = 1'b0;
    end
  end

  // Ack count for the current tenure: cleared on grant, saturating at 255.
  always_comb begin
    hold_cnt_nxt_s = hold_cnt_r;
    if (state_r == ST_ARB) begin
      hold_cnt_nxt_s = 8'd0;
    end else if (ack_i && (hold_cnt_r != 8'd255)) begin
      hold_cnt_nxt_s = hold_cnt_r + 8'd1;
    end else begin
      hold_cnt_nxt_s = hold_cnt_r;
    end
  end

  // Hold counter register.
  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      hold_cnt_r <= 8'd0;
    end else begin
      hold_cnt_r <= hold_cnt_nxt_s;
    end
  end
`else
  assign mask_s = 1'b0;
`endif

  // State, owner and rotation pointer registers; last resets so that port 0 wins first.
  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      state_r <= ST_ARB;
      own_r   <= '0;
      last_r  <= IDX_W'(NUM_PORTS - 1);
    end else begin
      state_r <= state_nxt_s;
      own_r   <= own_nxt_s;
      last_r  <= last_nxt_s;
    end
  end

  // Next state: grant on any request; release when the owner drops acc or is preempted.
  always_comb begin
    state_nxt_s = state_r;
    own_nxt_s   = own_r;
    last_nxt_s  = last_r;
    case (state_r)
      ST_ARB: begin
        if (|p_acc_i) begin
          state_nxt_s = ST_OWN;
          own_nxt_s   = pick_s;
          last_nxt_s  = pick_s;
        end else begin
          state_nxt_s = ST_ARB;
        end
      end
      ST_OWN: begin
        if (!p_acc_i[own_r] || mask_s) begin
          state_nxt_s = ST_ARB;
        end else begin
          state_nxt_s = ST_OWN;
        end
      end
      default: begin
        state_nxt_s = ST_ARB;
      end
    endcase
  end

  // Outputs: the owner's request is routed through and only the owner sees ack.
  always_comb begin
    grant_o = '0;
    acc_o   = 1'b0;
    p_ack_o = '0;
    adr_o   = 32'h0000_0000;
    dat_o   = 16'h0000;
    sel_o   = 2'b00;
    we_o    = 1'b0;
    case (state_r)
      ST_OWN: begin
        grant_o = own_oh_s;
        acc_o   = p_acc_i[own_r] & ~mask_s;
        p_ack_o = own_oh_s & {NUM_PORTS{ack_i}};
        adr_o   = p_adr_i[int'(own_r)*32 +: 32];
        dat_o   = p_dat_i[int'(own_r)*16 +: 16];
        sel_o   = p_sel_i[int'(own_r)*2 +: 2];
        we_o    = p_we_i[own_r];
      end
      ST_ARB: begin
        grant_o = '0;
      end
      default: begin
        grant_o = '0;
      end
    endcase
  end

  assign p_dat_o = dat_i;
  assign p_adr_o = adr_i;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed scenarios plus randomized requesters, checked every cycle
// against a behavioural arbiter model kept in the bench.
`timescale 1ns/1ps
module tb_sdram_arbiter;

  localparam int N = 3;
`ifdef SDRAM_ARB_FAIRNESS_EN
  localparam int MAX_HOLD = 4;
`else
  localparam int MAX_HOLD = 8;
`endif

  logic              sdram_clk = 1'b0;
  logic              sdram_rst_n;
  logic [N*32-1:0]   p_adr_i;
  logic [N*16-1:0]   p_dat_i;
  logic [N*2-1:0]    p_sel_i;
  logic [N-1:0]      p_we_i;
  logic [N-1:0]      p_acc_i;
  logic [N-1:0]      p_ack_o;
  logic [15:0]       p_dat_o;
  logic [31:0]       p_adr_o;
  logic [N-1:0]      grant_o;
  logic [31:0]       adr_o;
  logic [15:0]       dat_o;
  logic [1:0]        sel_o;
  logic              we_o;
  logic              acc_o;
  logic              ack_i;
  logic [15:0]       dat_i;
  logic [31:0]       adr_i;

  int n_checks = 0;
  int n_errors = 0;

  always #5 sdram_clk = ~sdram_clk;

  sdram_arbiter #(.NUM_PORTS(N), .MAX_HOLD(MAX_HOLD)) dut (
    .sdram_clk  (sdram_clk),
    .sdram_rst_n(sdram_rst_n),
    .p_adr_i    (p_adr_i),
    .p_dat_i    (p_dat_i),
    .p_sel_i    (p_sel_i),
    .p_we_i     (p_we_i),
    .p_acc_i    (p_acc_i),
    .p_ack_o    (p_ack_o),
    .p_dat_o    (p_dat_o),
    .p_adr_o    (p_adr_o),
    .grant_o    (grant_o),
    .adr_o      (adr_o),
    .dat_o      (dat_o),
    .sel_o      (sel_o),
    .we_o       (we_o),
    .acc_o      (acc_o),
    .ack_i      (ack_i),
    .dat_i      (dat_i),
    .adr_i      (adr_i)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: owner as an int (-1 = none), rotation by modulo arithmetic.
  int           m_own, m_last, m_hold, m_cand;
  logic         m_found;
  logic [N-1:0] e_grant, e_ack;
  logic         e_acc, e_mask;
  logic [31:0]  e_adr;
  logic [15:0]  e_dat;
  logic [1:0]   e_sel;
  logic         e_we;

  always @(negedge sdram_clk) begin
    if (!sdram_rst_n) begin
      check("rst_grant", grant_o, 0);
      check("rst_acc", acc_o, 0);
      check("rst_ack", p_ack_o, 0);
      check("rst_adr_o", adr_o, 0);
      check("rst_dat_o", dat_o, 0);
      check("rst_we_o", {sel_o, we_o}, 0);
      check("rst_bcast", {p_adr_o, p_dat_o}, {adr_i, dat_i});
      m_own  = -1;
      m_last = N - 1;
      m_hold = 0;
    end else begin
      e_grant = '0; e_ack = '0; e_acc = 1'b0; e_mask = 1'b0;
      e_adr = 32'h0; e_dat = 16'h0; e_sel = 2'b00; e_we = 1'b0;
      if (m_own >= 0) begin
`ifdef SDRAM_ARB_FAIRNESS_EN
        e_mask = ack_i && (m_hold == MAX_HOLD - 1) && ((p_acc_i & ~(N'(1) << m_own)) != '0);
`endif
        e_grant = N'(1) << m_own;
        e_acc   = p_acc_i[m_own] && !e_mask;
        e_ack   = ack_i ? e_grant : '0;
        e_adr   = p_adr_i[m_own*32 +: 32];
        e_dat   = p_dat_i[m_own*16 +: 16];
        e_sel   = p_sel_i[m_own*2 +: 2];
        e_we    = p_we_i[m_own];
      end
      check("model_grant", grant_o, e_grant);
      check("model_acc", acc_o, e_acc);
      check("model_ack", p_ack_o, e_ack);
      check("model_adr", adr_o, e_adr);
      check("model_dat", dat_o, e_dat);
      check("model_sel", sel_o, e_sel);
      check("model_we", we_o, e_we);
      check("model_bcast", {p_adr_o, p_dat_o}, {adr_i, dat_i});
      if (m_own < 0) begin
        m_found = 1'b0;
        for (int i = 1; i <= N; i++) begin
          m_cand = (m_last + i) % N;
          if (!m_found && p_acc_i[m_cand]) begin
            m_own   = m_cand;
            m_found = 1'b1;
          end
        end
        if (m_found) begin
          m_last = m_own;
          m_hold = 0;
        end
      end else begin
        if (ack_i && m_hold < 255) m_hold++;
        if (!p_acc_i[m_own] || e_mask) m_own = -1;
      end
    end
  end

  task automatic tick();
    @(posedge sdram_clk);
    #1;
  endtask

  task automatic set_port(input int k, input logic [31:0] a, input logic [15:0] d, input logic [1:0] s, input logic w);
    p_adr_i[k*32 +: 32] = a;
    p_dat_i[k*16 +: 16] = d;
    p_sel_i[k*2 +: 2]   = s;
    p_we_i[k]           = w;
  endtask

  task automatic do_reset();
    sdram_rst_n = 1'b0;
    p_acc_i     = '0;
    ack_i       = 1'b0;
    repeat (2) tick();
    sdram_rst_n = 1'b1;
  endtask

  logic [N-1:0] pending, acked, prev_g, req;
  logic         requeued;
  int           zero_run;
  logic [N-1:0] seen[$];
  int           gaps[$];
  logic [N-1:0] rr_exp [4];

  initial begin
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
    sdram_rst_n = 1'b0;
    p_adr_i = '0; p_dat_i = '0; p_sel_i = '0; p_we_i = '0;
    p_acc_i = '1; ack_i = 1'b0; dat_i = 16'h0; adr_i = 32'h0;

    // Reset with every port requesting
    tick(); #3;
    check("reset_grant", grant_o, 3'b000);
    check("reset_acc", acc_o, 1'b0);
    tick();
    sdram_rst_n = 1'b1;
    tick(); #3;
    check("post_reset_grant", grant_o, 3'b001);
    check("post_reset_acc", acc_o, 1'b1);
    p_acc_i = '0;
    tick(); tick();

    // Single write from port 1
    set_port(1, 32'h0000_1234, 16'hBEEF, 2'b11, 1'b1);
    p_acc_i = 3'b010;
    tick();
    ack_i = 1'b1; #2;
    check("wr_grant", grant_o, 3'b010);
    check("wr_adr", adr_o, 32'h0000_1234);
    check("wr_dat", dat_o, 16'hBEEF);
    check("wr_we_sel", {we_o, sel_o}, 3'b111);
    check("wr_acc", acc_o, 1'b1);
    check("wr_ack", p_ack_o, 3'b010);
    tick();
    ack_i = 1'b0; p_acc_i = '0; #2;
    check("wr_hold_grant", grant_o, 3'b010);
    tick(); #2;
    check("wr_release_grant", grant_o, 3'b000);

    // Round robin: every port one access, then port 0 again
    do_reset();
    pending = '1; acked = '0; prev_g = '0; zero_run = 0; requeued = 1'b0;
    for (int c = 0; c < 20; c++) begin
      pending &= ~acked;
      if (acked[2] && !requeued) begin
        pending[0] = 1'b1;
        requeued   = 1'b1;
      end
      p_acc_i = pending;
      #1; ack_i = |(grant_o & p_acc_i);
      #1; acked = p_ack_o;
      if (grant_o == '0) begin
        zero_run++;
      end else begin
        if (prev_g == '0) begin
          seen.push_back(grant_o);
          gaps.push_back(zero_run);
        end
        zero_run = 0;
      end
      prev_g = grant_o;
      tick();
    end
    ack_i = 1'b0;
    check("rr_count", seen.size(), 4);
    for (int i = 0; i < 4 && i < seen.size(); i++) begin
      check("rr_order", seen[i], rr_exp[i]);
      if (i > 0) check("rr_gap", gaps[i], 1);
    end

    // Read burst: data broadcast while port 0 takes over
    set_port(2, 32'h0000_0100, 16'h0000, 2'b11, 1'b0);
    set_port(0, 32'h0000_2000, 16'h5A5A, 2'b01, 1'b0);
    p_acc_i = 3'b100;
    tick();
    dat_i = 16'hD000; adr_i = 32'h0000_0100; ack_i = 1'b1; #2;
    check("burst_grant_p2", grant_o, 3'b100);
    check("burst_ack_p2", p_ack_o, 3'b100);
    tick();
    ack_i = 1'b0; p_acc_i = 3'b001;
    for (int b = 1; b <= 7; b++) begin
      adr_i = 32'h0000_0100 + 32'(2 * b);
      dat_i = 16'hD000 + 16'(b);
      #2;
      check("burst_adr", p_adr_o, 32'h0000_0100 + 32'(2 * b));
      check("burst_dat", p_dat_o, 16'hD000 + 16'(b));
      check("burst_no_ack", p_ack_o, 3'b000);
      if (b >= 3) check("burst_grant_p0", grant_o, 3'b001);
      tick();
    end
    ack_i = 1'b1; #2;
    check("burst_ack_p0", p_ack_o, 3'b001);
    tick();
    ack_i = 1'b0; p_acc_i = '0;
    tick(); tick();

    // Port 0 hogs while port 1 waits
    do_reset();
    p_acc_i = 3'b011;
    tick();
`ifdef SDRAM_ARB_FAIRNESS_EN
    for (int c = 0; c < 4; c++) begin
      ack_i = 1'b0; #1;
      ack_i = |(grant_o & p_acc_i); #1;
      check("fair_grant_p0", grant_o, 3'b001);
      check("fair_ack_p0", p_ack_o, 3'b001);
      check("fair_acc", acc_o, (c < 3) ? 1'b1 : 1'b0);
      tick();
    end
    ack_i = 1'b0; #2;
    check("fair_arb_gap", grant_o, 3'b000);
    tick(); #2;
    check("fair_grant_p1", grant_o, 3'b010);
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0; p_acc_i = 3'b001;
`else
    for (int c = 0; c < 20; c++) begin
      ack_i = 1'b0; #1;
      ack_i = |(grant_o & p_acc_i); #1;
      check("hog_grant_p0", grant_o, 3'b001);
      check("hog_acc", acc_o, 1'b1);
      check("hog_ack_p0", p_ack_o, 3'b001);
      tick();
    end
    ack_i = 1'b0; p_acc_i = 3'b010; #2;
    check("hog_drop_acc", acc_o, 1'b0);
    tick(); #2;
    check("hog_arb_gap", grant_o, 3'b000);
    tick(); #2;
    check("hog_grant_p1", grant_o, 3'b010);
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
`endif
    p_acc_i = '0;
    repeat (3) tick();

    // Stray ack with no owner is dropped
    ack_i = 1'b1; #2;
    check("stray_ack", p_ack_o, 3'b000);
    check("stray_grant", grant_o, 3'b000);
    tick();
    ack_i = 1'b0;

    // Reset asserted mid-transaction
    p_acc_i = 3'b010;
    tick();
    ack_i = 1'b1;
    tick();
    sdram_rst_n = 1'b0; #1;
    check("midrst_grant", grant_o, 3'b000);
    check("midrst_acc", acc_o, 1'b0);
    check("midrst_ack", p_ack_o, 3'b000);
    tick();
    ack_i = 1'b0; p_acc_i = '0;
    tick();
    sdram_rst_n = 1'b1;

    // Randomized requesters; the model process checks every cycle
    req = '0; acked = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (req[k] && acked[k]) begin
          if ($urandom_range(1, 0) == 0) req[k] = 1'b0;
          else set_port(k, $urandom, 16'($urandom), 2'($urandom), 1'($urandom));
        end else if (!req[k] && $urandom_range(3, 0) == 0) begin
          req[k] = 1'b1;
          set_port(k, $urandom, 16'($urandom), 2'($urandom), 1'($urandom));
        end
      end
      p_acc_i = req;
      dat_i = 16'($urandom);
      adr_i = $urandom;
      #1;
      ack_i = (|(grant_o & p_acc_i)) && ($urandom_range(1, 0) == 1);
      if ($urandom_range(31, 0) == 0) ack_i = 1'b1;
      #1; acked = p_ack_o;
      tick();
    end
    p_acc_i = '0; ack_i = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
